ex: RTL and testbench
=====================

// Module: ex
// PURPOSE
// - Execute stage. Consumes the decoded operands and ALU controls that the decode stage produces, after the id_ex register.
// - Computes the logic, shift and LUI results. Runs DIV/DIVU on an iterative 32-cycle divider that writes HI/LO.
// - Drives ex_mem, and returns the forwarding triple (ex_wdata/ex_waddr/ex_wreg) to decode.
// - Raises stallreq while a divide is in flight.
// PARAMETERS
// - DIV_CYCLES  32  quotient bits resolved, one per cycle. The only legal value is 32.
// PORTS
// - clk          in   1   rising-edge clock
// - rst          in   1   reset: rst, synchronous, active-high
// - flush_i      in   1   pipeline flush; aborts any divide in progress
// - aluop_i      in   8   `AluOpBus, from id_ex
// - alusel_i     in   3   `AluSelBus, from id_ex
// - reg1_i       in   32  source operand 1 (rs value, or the immediate/shamt)
// - reg2_i       in   32  source operand 2 (rt value, or the immediate)
// - waddr_i      in   5   destination register
// - wreg_i       in   1   write enable
// - wdata_o      out  32  result to ex_mem; also the forwarding data to decode
// - waddr_o      out  5   destination register to ex_mem and decode
// - wreg_o       out  1   write enable to ex_mem and decode
// - hi_o         out  32  divide remainder
// - lo_o         out  32  divide quotient
// - whilo_o      out  1   HI/LO write strobe, one cycle
// - stallreq_o   out  1   stall request to the pipeline controller
// BEHAVIOUR
// - Reset (rst=1 at clk edge): divider state=IDLE, internal registers cleared.
//   - While rst=1: all outputs are 0, including stallreq_o and whilo_o.
// - Non-divide ops: purely combinational, zero added latency.
//   - waddr_o=waddr_i, wreg_o=wreg_i.
//   - EXE_OR_OP: a|b. EXE_AND_OP: a&b. EXE_XOR_OP: a^b. EXE_NOR_OP: ~(a|b).
//   - EXE_LUI_OP: b.
//   - EXE_SLL_OP: b<<a[4:0]. EXE_SRL_OP: b>>a[4:0]. EXE_SRA_OP: $signed(b)>>>a[4:0].
//   - Here a=reg1_i and b=reg2_i. Only a[4:0] is used as the shift amount.
//   - wdata_o is selected by alusel_i (LOGIC/SHIFT/ARITH). EXE_RES_NOP or an unknown select gives 0.
// - DIV/DIVU (EXE_DIV_OP / EXE_DIVU_OP):
//   - wreg_o is forced to 0. Results go only to HI/LO.
//   - FSM states: IDLE, BUSY, BYZERO, DONE.
//   - IDLE with a divide op and reg2_i!=0 -> BUSY.
//     - Latches |dividend|, |divisor| and both sign bits. Magnitudes are taken only for DIV.
//     - Clears the iteration counter.
//   - IDLE with a divide op and reg2_i==0 -> BYZERO.
//   - BUSY: restoring shift-subtract, one quotient bit per cycle, 64-bit remainder/quotient register.
//     - After DIV_CYCLES iterations -> DONE.
//   - BYZERO -> DONE, with hi=reg1_i and lo=32'hFFFF_FFFF.
//   - DONE:
//     - Sign correction for DIV: quotient is negated when the signs differ; remainder takes the dividend's sign.
//     - whilo_o=1 for exactly this cycle; hi_o/lo_o are valid.
//     - stallreq_o=0, so the pipeline advances.
//     - Next state is IDLE.
//   - stallreq_o=1 combinationally in the IDLE cycle that sees the divide, and in every BUSY and BYZERO cycle.
//   - Latency: issue cycle T, whilo_o at T+33 (T+2 for divide-by-zero).
//   - The operands latched in IDLE are used for the whole divide. Changes on reg1_i/reg2_i during BUSY are ignored.
//   - DIVU: no sign handling. 0x8000_0000 is a plain unsigned value.
//   - DIV of 0x8000_0000 by -1: quotient 0x8000_0000, remainder 0 (wrap).
// - flush_i=1 at any edge: state -> IDLE, no whilo_o is produced.
//   - stallreq_o is 0 in the flush cycle.
//   - flush takes priority over a divide completing in the same cycle.
// - rst mid-divide: same as flush, and all outputs are cleared.
// - While BUSY, outputs are driven from the id_ex inputs, which the controller holds. No bubble is generated here.
// STRUCTURE
// - define.v (shared): adds EXE_DIV_OP, EXE_DIVU_OP and the DIV_* FSM state encodings. The existing
//   `AluOpBus, `AluSelBus, `EXE_RES_*, `ZeroWord, `WriteEna and `RstEna are reused.
// - Sub-module div_seq: holds the FSM, the counter and the 64-bit remainder register.
//   - Inputs: start, signed, a, b, annul.
//   - Outputs: result[63:0], ready.
// - ex itself keeps the combinational result mux and the stallreq/wreg gating.
// TESTING
// - ORI path: reg1=32'h0000_1100, reg2=32'h0000_0020, aluop OR, alusel LOGIC, wreg=1, waddr=5
//   -> same cycle wdata_o=32'h0000_1120, waddr_o=5, wreg_o=1.
// - SRA: reg1=4, reg2=32'hF000_0000 -> wdata_o=32'hFF00_0000.
//   - SRL with the same operands -> wdata_o=32'h0F00_0000.
// - DIV: reg1=-7, reg2=2 held under stall.
//   - stallreq_o=1 for 33 cycles.
//   - At T+33: whilo_o=1, lo_o=32'hFFFF_FFFD (-3), hi_o=32'hFFFF_FFFF (-1), wreg_o=0 throughout.
// - DIVU: reg1=32'hFFFF_FFFF, reg2=16 -> lo_o=32'h0FFF_FFFF, hi_o=15 at T+33.
// - Divide-by-zero: reg1=9, reg2=0 -> stallreq 2 cycles, whilo_o at T+2, hi_o=9, lo_o=32'hFFFF_FFFF.
// - Abort: assert flush_i at BUSY iteration 10 -> next cycle state IDLE, stallreq_o=0, no whilo_o pulse.
//   - Repeat the case with rst instead of flush_i -> all outputs 0.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   - ALU operation codes (aluop) and result-group selects (alusel)
//   - divider FSM state encoding
package ex_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // aluop encodings
  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_LUI_OP  = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // alusel encodings (result group)
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  // divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BUSY   = 2'b01,
    DIV_BYZERO = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_t;

endpackage

// File: rtl/ex_div_seq.sv
// div_seq: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          a divide op is presented (acted on only in IDLE)
//   is_signed      1 = DIV (two's complement), 0 = DIVU
//   a, b           dividend / divisor, latched at start
//   annul          abort: return to IDLE, suppress ready
//   result[63:0]   {remainder, quotient}, sign-corrected, valid when ready
//   ready          one-cycle completion strobe (DONE state)
module div_seq
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  div_state_t  state_reg, state_next;
  logic [5:0]  count_reg;
  logic [63:0] rem_reg;      // {partial remainder, quotient bits}
  logic [31:0] b_mag_reg;
  logic [31:0] a_raw_reg;    // unmodified dividend, returned as HI on divide-by-zero
  logic        a_neg_reg;
  logic        b_neg_reg;

  logic [31:0] a_mag, b_mag;
  logic [32:0] top;
  logic        ge;
  logic [31:0] diff;
  logic [63:0] rem_step;
  logic [31:0] q_raw, r_raw, q_fix, r_fix;

  assign a_mag = (is_signed && a[31]) ? (ZERO_WORD - a) : a;
  assign b_mag = (is_signed && b[31]) ? (ZERO_WORD - b) : b;

  // Shift left one place, then try to subtract the divisor from the upper half.
  // top is 33 bits so a divisor >= 2^31 (DIVU) never loses the carried-out bit.
  // When ge holds, the true difference is < 2^32, so a 32-bit subtract is exact.
  assign top  = rem_reg[63:31];
  assign ge   = (top >= {1'b0, b_mag_reg});
  assign diff = top[31:0] - b_mag_reg;

  always_comb begin
    if (ge) begin
      rem_step = {diff, rem_reg[30:0], 1'b1};
    end else begin
      rem_step = {rem_reg[62:0], 1'b0};
    end
  end

  // Next-state logic; annul overrides everything, including completion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DIV_IDLE: begin
        if (start) begin
          state_next = (b == ZERO_WORD) ? DIV_BYZERO : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (count_reg == 6'(DIV_CYCLES - 1)) begin
          state_next = DIV_DONE;
        end
      end
      DIV_BYZERO: state_next = DIV_DONE;
      DIV_DONE:   state_next = DIV_IDLE;
      default:    state_next = DIV_IDLE;
    endcase
    if (annul) begin
      state_next = DIV_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DIV_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers only reload on a start from IDLE, so an annul
  // simply leaves stale contents that the next start overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      rem_reg   <= '0;
      b_mag_reg <= '0;
      a_raw_reg <= '0;
      a_neg_reg <= 1'b0;
      b_neg_reg <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            rem_reg   <= {ZERO_WORD, a_mag};
            b_mag_reg <= b_mag;
            a_raw_reg <= a;
            a_neg_reg <= is_signed & a[31];
            b_neg_reg <= is_signed & b[31];
            count_reg <= '0;
          end
        end
        DIV_BUSY: begin
          rem_reg   <= rem_step;
          count_reg <= count_reg + 6'd1;
        end
        DIV_BYZERO: begin
          // Fixed result; clearing the signs makes DONE pass it through untouched.
          rem_reg   <= {a_raw_reg, 32'hFFFF_FFFF};
          a_neg_reg <= 1'b0;
          b_neg_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sign correction: quotient negative when signs differ, remainder follows dividend.
  assign q_raw  = rem_reg[31:0];
  assign r_raw  = rem_reg[63:32];
  assign q_fix  = (a_neg_reg ^ b_neg_reg) ? (ZERO_WORD - q_raw) : q_raw;
  assign r_fix  = a_neg_reg ? (ZERO_WORD - r_raw) : r_raw;
  assign result = {r_fix, q_fix};
  assign ready  = (state_reg == DIV_DONE) && !annul;

endmodule

// File: rtl/ex.sv
// ex: execute stage.
//   Combinational logic/shift/LUI results with zero latency; DIV/DIVU run on
//   the iterative div_seq and write HI/LO via a one-cycle whilo_o strobe.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush_i              pipeline flush, aborts an in-flight divide
//   aluop_i, alusel_i    operation and result-group select from id_ex
//   reg1_i, reg2_i       operands (a, b)
//   waddr_i, wreg_i      destination register and write enable
//   wdata_o/waddr_o/wreg_o  result to ex_mem, also forwarded to decode
//   hi_o, lo_o           divide remainder / quotient, valid with whilo_o
//   whilo_o              HI/LO write strobe
//   stallreq_o           stall request while a divide is in flight
module ex
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  waddr_i,
  input  logic        wreg_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        wreg_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o
);

  logic [31:0] logic_res, shift_res, res;
  logic [4:0]  sh;
  logic        is_div;
  logic [63:0] div_result;
  logic        div_ready;

  assign sh     = reg1_i[4:0];
  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  always_comb begin
    logic_res = ZERO_WORD;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      EXE_LUI_OP: logic_res = reg2_i;
      default:    logic_res = ZERO_WORD;
    endcase
  end

  always_comb begin
    shift_res = ZERO_WORD;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << sh;
      EXE_SRL_OP: shift_res = reg2_i >> sh;
      EXE_SRA_OP: shift_res = 32'($signed(reg2_i) >>> sh);
      default:    shift_res = ZERO_WORD;
    endcase
  end

  // There is no adder in this stage; the ARITH group carries the
  // pass-through ops (LUI) that are decoded alongside the logic ops.
  always_comb begin
    res = ZERO_WORD;
    case (alusel_i)
      EXE_RES_LOGIC: res = logic_res;
      EXE_RES_SHIFT: res = shift_res;
      EXE_RES_ARITH: res = logic_res;
      default:       res = ZERO_WORD;
    endcase
  end

  div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (is_div),
    .is_signed(aluop_i == EXE_DIV_OP),
    .a        (reg1_i),
    .b        (reg2_i),
    .annul    (flush_i),
    .result   (div_result),
    .ready    (div_ready)
  );

  // A divide op stalls until its DONE cycle; the op is held in id_ex meanwhile.
  assign stallreq_o = !rst && !flush_i && is_div && !div_ready;
  assign whilo_o    = !rst && div_ready;
  assign hi_o       = whilo_o ? div_result[63:32] : ZERO_WORD;
  assign lo_o       = whilo_o ? div_result[31:0]  : ZERO_WORD;

  assign wdata_o = rst ? ZERO_WORD : res;
  assign waddr_o = rst ? 5'd0 : waddr_i;
  assign wreg_o  = (rst || is_div) ? 1'b0 : wreg_i;

endmodule

// File: tb/tb_ex.sv
module tb_ex;
  import ex_pkg::*;

  logic        clk, rst, flush_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  waddr_i;
  logic        wreg_i;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic [4:0]  waddr_o;
  logic        wreg_o, whilo_o, stallreq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } div_exp_t;

  logic [31:0] comb_q[$];
  div_exp_t    div_q[$];

  ex #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i),
    .waddr_i(waddr_i), .wreg_i(wreg_i),
    .wdata_o(wdata_o), .waddr_o(waddr_o), .wreg_o(wreg_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at posedge+1.
  task automatic comb_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic [31:0] exp);
    logic [31:0] e;
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; waddr_i = wa; wreg_i = 1'b1;
    comb_q.push_back(exp);
    @(negedge clk);
    e = comb_q.pop_front();
    chk(tag, wdata_o, e);
    chk({tag, "_wr"}, {58'd0, wreg_o, waddr_o}, {58'd0, 1'b1, wa});
    $display("op %-6s a=%08h b=%08h wdata=%08h waddr=%0d wreg=%0b", tag, a, b, wdata_o, waddr_o, wreg_o);
    @(posedge clk); #1;
  endtask

  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b, input bit scramble);
    div_exp_t e;
    int idx = 0, stalls = 0;
    bit got = 0, wreg_seen = 0;
    aluop_i = op; alusel_i = EXE_RES_NOP; reg1_i = a; reg2_i = b; waddr_i = 5'd7; wreg_i = 1'b1;
    while (!got && idx < 100) begin
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (wreg_o) wreg_seen = 1;
      if (whilo_o) got = 1;
      else begin
        @(posedge clk); #1;
        idx++;
        if (scramble && idx > 3) begin
          reg1_i = $urandom; reg2_i = $urandom;
        end
      end
    end
    e = div_q.pop_front();
    chk({tag, "_lat"}, idx, e.lat);
    chk({tag, "_stall"}, stalls, e.lat);
    chk({tag, "_wreg"}, wreg_seen, 0);
    chk({tag, "_hi"}, hi_o, e.hi);
    chk({tag, "_lo"}, lo_o, e.lo);
    $display("div %-8s a=%08h b=%08h hi=%08h lo=%08h lat=%0d stalls=%0d", tag, a, b, hi_o, lo_o, idx, stalls);
    @(posedge clk); #1;
    aluop_i = EXE_NOP_OP; reg1_i = '0; reg2_i = '0;
    @(negedge clk);
    chk({tag, "_pulse1"}, {whilo_o, stallreq_o}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic abort_div(input string tag, input bit use_rst);
    int pulses = 0;
    aluop_i = EXE_DIV_OP; alusel_i = EXE_RES_NOP; reg1_i = -32'sd7; reg2_i = 32'd2;
    waddr_i = 5'd7; wreg_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    // now in the 10th BUSY cycle
    if (use_rst) rst = 1'b1; else flush_i = 1'b1;
    @(negedge clk);
    chk({tag, "_stall"}, stallreq_o, 0);
    if (use_rst)
      chk({tag, "_zero"}, {wdata_o, waddr_o, wreg_o, hi_o, lo_o, whilo_o}, '0);
    @(posedge clk); #1;
    rst = 1'b0; flush_i = 1'b0; aluop_i = EXE_NOP_OP;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (whilo_o || stallreq_o) pulses++;
    end
    chk({tag, "_nopulse"}, pulses, 0);
    $display("abort %-6s stall_after=%0b pulses=%0d", tag, stallreq_o, pulses);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    aluop_i = EXE_OR_OP; alusel_i = EXE_RES_LOGIC;
    reg1_i = 32'h0000_1234; reg2_i = 32'h00FF_0000; waddr_i = 5'd9; wreg_i = 1'b1;
    @(negedge clk);
    chk("rst_outs", {wdata_o, waddr_o, wreg_o, hi_o, lo_o, whilo_o, stallreq_o}, '0);
    $display("reset wdata=%08h waddr=%0d wreg=%0b stall=%0b", wdata_o, waddr_o, wreg_o, stallreq_o);
    @(posedge clk); #1;
    aluop_i = EXE_DIV_OP;
    @(negedge clk);
    chk("rst_div_stall", {stallreq_o, whilo_o, wreg_o}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;

    comb_op("ori",  EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000_1100, 32'h0000_0020, 5'd5, 32'h0000_1120);
    comb_op("sra",  EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'hF000_0000, 5'd3, 32'hFF00_0000);
    comb_op("srl",  EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'hF000_0000, 5'd3, 32'h0F00_0000);
    comb_op("sll",  EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h0000_00F1, 5'd4, 32'h0000_0F10);
    comb_op("and",  EXE_AND_OP, EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd6, 32'h0F00_0F00);
    comb_op("xor",  EXE_XOR_OP, EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd8, 32'hF00F_F00F);
    comb_op("nor",  EXE_NOR_OP, EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd10, 32'h00F0_00F0);
    comb_op("lui",  EXE_LUI_OP, EXE_RES_LOGIC, 32'h1234_5678, 32'hABCD_0000, 5'd11, 32'hABCD_0000);
    comb_op("nopsel", EXE_OR_OP, EXE_RES_NOP,  32'h1234_5678, 32'h1111_0000, 5'd12, 32'h0000_0000);
    comb_op("badsel", EXE_OR_OP, 3'b111,       32'h1234_5678, 32'h1111_0000, 5'd13, 32'h0000_0000);

    div_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, lat: 33});
    run_div("div_m7_2", EXE_DIV_OP, -32'sd7, 32'd2, 1'b0);
    div_q.push_back('{hi: 32'd15, lo: 32'h0FFF_FFFF, lat: 33});
    run_div("divu_ff", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16, 1'b1);
    div_q.push_back('{hi: 32'd0, lo: 32'h8000_0000, lat: 33});
    run_div("div_wrap", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    div_q.push_back('{hi: 32'd2, lo: 32'h2AAA_AAAA, lat: 33});
    run_div("divu_8m", EXE_DIVU_OP, 32'h8000_0000, 32'd3, 1'b0);
    div_q.push_back('{hi: 32'd9, lo: 32'hFFFF_FFFF, lat: 2});
    run_div("div_zero", EXE_DIV_OP, 32'd9, 32'd0, 1'b0);

    abort_div("flush", 1'b0);
    abort_div("rst", 1'b1);

    div_q.push_back('{hi: 32'd2, lo: 32'hFFFF_FFF2, lat: 33});
    run_div("div_post", EXE_DIV_OP, 32'd100, -32'sd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
